// File: rtl/reset_release_seq.sv
// Power-up / recovery sequencer: PHY reset hold, lock wait, calibration, core release.
// A bounded retry policy ends in a sticky lockout that only a reset clears.
module reset_release_seq #(
  parameter int unsigned PHY_HOLD     = 16,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned CAL_TIMEOUT  = 4096,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       async_reset_n_i,
  input  logic       reset_i,
  input  logic       phy_locked_i,
  input  logic       cal_done_i,
  output logic       phy_reset_o,
  output logic       cal_start_o,
  output logic       core_reset_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [3:0] retries_o
);

  typedef enum logic [2:0] {
    PHY_RST,
    WAIT_LOCK,
    CAL,
    CORE_REL,
    RUN,
    FAULT,
    LOCKOUT
  } state_e;

  // Terminal counts are the last cycle spent in a state (counter starts at 0).
  localparam logic [15:0] HOLD_LAST = 16'(PHY_HOLD - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] CAL_LAST  = 16'(CAL_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  retries_q, retries_d;
  logic [3:0]  retries_inc;
  logic [1:0]  sync_q;
  logic        lock;

  logic phy_reset_q, phy_reset_d;
  logic cal_start_q, cal_start_d;
  logic core_reset_q, core_reset_d;
  logic ready_q, ready_d;
  logic fault_q, fault_d;

  assign lock = sync_q[1];

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      sync_q <= 2'b00;
    end else if (reset_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], phy_locked_i};
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    retries_d   = retries_q;
    retries_inc = (retries_q == 4'hF) ? 4'hF : retries_q + 4'd1;

    unique case (state_q)
      PHY_RST: begin
        if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock)                   state_d = CAL;
        else if (cnt_q == LOCK_LAST) state_d = FAULT;
      end
      CAL: begin
        // Losing lock restarts the PHY; done is ignored on the start cycle.
        if (!lock)                               state_d = PHY_RST;
        else if ((cnt_q != 16'd0) && cal_done_i) state_d = CORE_REL;
        else if (cnt_q == CAL_LAST)              state_d = FAULT;
      end
      CORE_REL: state_d = RUN;
      RUN: begin
        if (!lock) state_d = PHY_RST;
      end
      FAULT: begin
        retries_d = retries_inc;
        state_d   = (32'(retries_inc) <= MAX_RETRY) ? PHY_RST : LOCKOUT;
      end
      LOCKOUT: state_d = LOCKOUT;
      default: state_d = PHY_RST;
    endcase

    if (reset_i) begin
      state_d   = PHY_RST;
      retries_d = 4'd0;
    end

    if (reset_i || (state_d != state_q)) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end

    // Outputs are decoded from the next state so the registers line up with it.
    phy_reset_d  = (state_d == PHY_RST) || (state_d == FAULT) || (state_d == LOCKOUT);
    core_reset_d = (state_d != RUN);
    ready_d      = (state_d == RUN);
    fault_d      = (state_d == LOCKOUT);
    cal_start_d  = (state_d == CAL) && (state_q != CAL);
  end

  always_ff @(posedge clk or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      state_q      <= PHY_RST;
      cnt_q        <= 16'd0;
      retries_q    <= 4'd0;
      phy_reset_q  <= 1'b1;
      cal_start_q  <= 1'b0;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retries_q    <= retries_d;
      phy_reset_q  <= phy_reset_d;
      cal_start_q  <= cal_start_d;
      core_reset_q <= core_reset_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

  assign phy_reset_o  = phy_reset_q;
  assign cal_start_o  = cal_start_q;
  assign core_reset_o = core_reset_q;
  assign ready_o      = ready_q;
  assign fault_o      = fault_q;
  assign retries_o    = retries_q;

endmodule

// File: tb/tb_reset_release_seq.sv
// Scoreboard bench for reset_release_seq: stimulus queues timestamped output
// vectors, a monitor pops one each time the DUT's output vector changes.
module tb_reset_release_seq;

  logic       clk = 1'b0;
  logic       async_reset_n_i;
  logic       reset_i;
  logic       phy_locked_i;
  logic       cal_done_i;
  logic       phy_reset_o;
  logic       cal_start_o;
  logic       core_reset_o;
  logic       ready_o;
  logic       fault_o;
  logic [3:0] retries_o;

  reset_release_seq dut (
    .clk             (clk),
    .async_reset_n_i (async_reset_n_i),
    .reset_i         (reset_i),
    .phy_locked_i    (phy_locked_i),
    .cal_done_i      (cal_done_i),
    .phy_reset_o     (phy_reset_o),
    .cal_start_o     (cal_start_o),
    .core_reset_o    (core_reset_o),
    .ready_o         (ready_o),
    .fault_o         (fault_o),
    .retries_o       (retries_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [8:0] vec;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // {phy_reset, cal_start, core_reset, ready, fault, retries}
  function automatic logic [8:0] ov(input logic p, input logic cs, input logic cr,
                                    input logic rd, input logic ft, input logic [3:0] r);
    return {p, cs, cr, rd, ft, r};
  endfunction
  function automatic logic [8:0] rst_v(input logic [3:0] r); return ov(1, 0, 1, 0, 0, r); endfunction
  function automatic logic [8:0] wl_v (input logic [3:0] r); return ov(0, 0, 1, 0, 0, r); endfunction
  function automatic logic [8:0] cs_v (input logic [3:0] r); return ov(0, 1, 1, 0, 0, r); endfunction
  function automatic logic [8:0] run_v(input logic [3:0] r); return ov(0, 0, 0, 1, 0, r); endfunction
  function automatic logic [8:0] lo_v (input logic [3:0] r); return ov(1, 0, 1, 0, 1, r); endfunction

  task automatic exp_at(input int c, input logic [8:0] v);
    sb.push_back('{cyc: c, vec: v});
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: sample 2 time units after each rising edge, pop on every change.
  logic [8:0] mon_prev;
  logic [8:0] mon_cur;
  bit         mon_have = 1'b0;
  exp_t       mon_e;

  always begin
    @(posedge clk);
    #2;
    mon_cur = {phy_reset_o, cal_start_o, core_reset_o, ready_o, fault_o, retries_o};
    if (!mon_have || (mon_cur !== mon_prev)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_change: got vector %09b at cycle %0d, expected no change",
                 mon_cur, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("out_vector", int'(mon_cur), int'(mon_e.vec));
        check("out_cycle", cyc, mon_e.cyc);
      end
      mon_prev = mon_cur;
      mon_have = 1'b1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
    $fatal(1, "watchdog expired");
  end

  int n;

  initial begin
    async_reset_n_i = 1'b1;
    reset_i         = 1'b1;
    phy_locked_i    = 1'b1;
    cal_done_i      = 1'b0;
    exp_at(1, rst_v(0));
    #1 async_reset_n_i = 1'b0;
    goto_cyc(3);
    async_reset_n_i = 1'b0;
    async_reset_n_i = 1'b1;

    // Nominal bring-up: 16-cycle PHY hold, single cal_start, done 10 cycles later.
    goto_cyc(5);
    n = cyc;
    reset_i = 1'b0;
    exp_at(n + 16, wl_v(0));
    exp_at(n + 17, cs_v(0));
    exp_at(n + 18, wl_v(0));
    goto_cyc(n + 27);
    cal_done_i = 1'b1;
    exp_at(n + 29, run_v(0));

    // Lock loss in RUN; cal_done held high also checks it is ignored on CAL's first cycle.
    goto_cyc(n + 40);
    n = cyc;
    phy_locked_i = 1'b0;
    exp_at(n + 3, rst_v(0));
    goto_cyc(n + 3);
    phy_locked_i = 1'b1;
    exp_at(n + 19, wl_v(0));
    exp_at(n + 20, cs_v(0));
    exp_at(n + 21, wl_v(0));
    exp_at(n + 23, run_v(0));

    // Calibration timeout, then a successful retry.
    goto_cyc(n + 40);
    n = cyc;
    phy_locked_i = 1'b0;
    cal_done_i   = 1'b0;
    exp_at(n + 3, rst_v(0));
    goto_cyc(n + 3);
    phy_locked_i = 1'b1;
    exp_at(n + 19,   wl_v(0));
    exp_at(n + 20,   cs_v(0));
    exp_at(n + 21,   wl_v(0));
    exp_at(n + 4116, rst_v(0));
    exp_at(n + 4117, rst_v(1));
    exp_at(n + 4133, wl_v(1));
    exp_at(n + 4134, cs_v(1));
    exp_at(n + 4135, wl_v(1));
    goto_cyc(n + 4140);
    cal_done_i = 1'b1;
    exp_at(n + 4142, run_v(1));

    // cal_done on the last permitted CAL cycle wins over the timeout.
    goto_cyc(n + 4160);
    n = cyc;
    phy_locked_i = 1'b0;
    cal_done_i   = 1'b0;
    exp_at(n + 3, rst_v(1));
    goto_cyc(n + 3);
    phy_locked_i = 1'b1;
    exp_at(n + 19, wl_v(1));
    exp_at(n + 20, cs_v(1));
    exp_at(n + 21, wl_v(1));
    goto_cyc(n + 4115);
    cal_done_i = 1'b1;
    exp_at(n + 4117, run_v(1));

    // One-cycle reset_i pulse mid-CAL clears retries and restarts the sequence.
    goto_cyc(n + 4130);
    n = cyc;
    phy_locked_i = 1'b0;
    cal_done_i   = 1'b0;
    exp_at(n + 3, rst_v(1));
    goto_cyc(n + 3);
    phy_locked_i = 1'b1;
    exp_at(n + 19, wl_v(1));
    exp_at(n + 20, cs_v(1));
    exp_at(n + 21, wl_v(1));
    goto_cyc(n + 30);
    reset_i = 1'b1;
    exp_at(n + 31, rst_v(0));
    goto_cyc(n + 31);
    reset_i = 1'b0;
    exp_at(n + 47, wl_v(0));
    exp_at(n + 48, cs_v(0));
    exp_at(n + 49, wl_v(0));

    // Lock loss in CAL, then lock arriving on the last WAIT_LOCK cycle wins.
    goto_cyc(n + 55);
    n = cyc;
    phy_locked_i = 1'b0;
    exp_at(n + 3,  rst_v(0));
    exp_at(n + 19, wl_v(0));
    goto_cyc(n + 1040);
    phy_locked_i = 1'b1;
    exp_at(n + 1043, cs_v(0));
    exp_at(n + 1044, wl_v(0));
    goto_cyc(n + 1045);
    cal_done_i = 1'b1;
    exp_at(n + 1047, run_v(0));

    // Permanent lock loss: four lock timeouts, then LOCKOUT.
    goto_cyc(n + 1060);
    n = cyc;
    phy_locked_i = 1'b0;
    cal_done_i   = 1'b0;
    exp_at(n + 3, rst_v(0));
    for (int k = 0; k < 4; k++) begin
      exp_at(n + 19 + 1041 * k,   wl_v(4'(k)));
      exp_at(n + 1043 + 1041 * k, rst_v(4'(k)));
      if (k < 3) exp_at(n + 1044 + 1041 * k, rst_v(4'(k + 1)));
      else       exp_at(n + 1044 + 1041 * k, lo_v(4'd4));
    end
    goto_cyc(n + 4167 + 50);
    phy_locked_i = 1'b1;
    goto_cyc(cyc + 60);

    // Async reset pulse between edges while in LOCKOUT.
    n = cyc;
    exp_at(n + 1, rst_v(0));
    async_reset_n_i = 1'b0;
    #1;
    check("async_immediate",
          int'({phy_reset_o, cal_start_o, core_reset_o, ready_o, fault_o, retries_o}),
          int'(rst_v(0)));
    #1 async_reset_n_i = 1'b1;
    exp_at(n + 16, wl_v(0));
    exp_at(n + 17, cs_v(0));
    exp_at(n + 18, wl_v(0));
    goto_cyc(n + 20);
    cal_done_i = 1'b1;
    exp_at(n + 22, run_v(0));

    goto_cyc(cyc + 20);
    check("scoreboard_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reset_release_seq.md
RESET_RELEASE_SEQ -- requirements
Module: reset_release_seq

Interface
REQ-001 SHALL have parameter PHY_HOLD, default 16, cycles phy_reset_o is held after each entry to PHY_RST (range 1..65535).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024, maximum cycles spent in WAIT_LOCK before a fault.
REQ-003 SHALL have parameter CAL_TIMEOUT, default 4096, maximum cycles spent in CAL before a fault.
REQ-004 SHALL have parameter MAX_RETRY, default 3, number of fault retries allowed before lockout (range 0..15).
REQ-005 SHALL have port clk  input  1  single clock for all logic.
REQ-006 SHALL have port async_reset_n_i  input  1  asynchronous active-low reset.
REQ-007 SHALL have port reset_i  input  1  synchronous active-high reset from the upstream reset_block (reset_o), already in clk domain.
REQ-008 SHALL have port phy_locked_i  input  1  PHY/MMCM lock, asynchronous to clk.
REQ-009 SHALL have port cal_done_i  input  1  calibration done level, synchronous to clk.
REQ-010 SHALL have port phy_reset_o  output  1  active-high PHY reset.
REQ-011 SHALL have port cal_start_o  output  1  one-cycle calibration start pulse.
REQ-012 SHALL have port core_reset_o  output  1  active-high core-logic reset.
REQ-013 SHALL have port ready_o  output  1  high only in RUN.
REQ-014 SHALL have port fault_o  output  1  high only in LOCKOUT.
REQ-015 SHALL have port retries_o  output  4  count of faults since last reset.

Function
REQ-016 All outputs SHALL be registered; states: PHY_RST, WAIT_LOCK, CAL, CORE_REL, RUN, FAULT, LOCKOUT.
REQ-017 phy_locked_i SHALL pass through a 2-flop synchronizer; "lock" below means the synchronized value (2-cycle latency).
REQ-018 PHY_RST: phy_reset_o=1, core_reset_o=1; exit to WAIT_LOCK after exactly PHY_HOLD cycles in the state.
REQ-019 WAIT_LOCK: phy_reset_o=0; lock=1 -> CAL; otherwise on the LOCK_TIMEOUT-th cycle in state -> FAULT; lock takes priority if both occur in the same cycle.
REQ-020 CAL: cal_start_o=1 on first cycle in state only; cal_done_i=1 (sampled from second cycle on) -> CORE_REL; CAL_TIMEOUT-th cycle -> FAULT; done wins ties; lock=0 in CAL -> PHY_RST.
REQ-021 CORE_REL: one cycle, then RUN; core_reset_o=0 from first RUN cycle.
REQ-022 RUN: ready_o=1, core_reset_o=0; lock=0 -> PHY_RST (ready_o=0, core_reset_o=1, phy_reset_o=1 next cycle), retries_o unchanged.
REQ-023 FAULT: one cycle; retries_o increments (saturate at 15); if post-increment retries_o <= MAX_RETRY -> PHY_RST, else -> LOCKOUT.
REQ-024 LOCKOUT: phy_reset_o=1, core_reset_o=1, fault_o=1; held until reset_i or async_reset_n_i.
REQ-025 The per-state cycle counter SHALL clear on every state transition, be 16 bits wide, and never wrap within a state.

Reset
REQ-026 async_reset_n_i=0 SHALL immediately force state PHY_RST, counter 0, phy_reset_o=1, core_reset_o=1, cal_start_o=0, ready_o=0, fault_o=0, retries_o=0, synchronizer flops 0.
REQ-027 reset_i=1 at a clock edge SHALL apply the same values synchronously, from any state including mid-CAL and LOCKOUT, and hold them while high.
REQ-028 After release of both resets the PHY_HOLD count SHALL begin on the first edge with reset_i=0.

Verification
REQ-029 Nominal: release resets, phy_locked_i=1 constant, cal_done_i rises 10 cycles after cal_start_o -> phy_reset_o low after 16 cycles, single cal_start_o pulse, ready_o=1 two cycles after cal_done_i seen, retries_o=0.
REQ-030 Lock timeout: phy_locked_i=0 forever, MAX_RETRY=3 -> four WAIT_LOCK periods of 1024 cycles, retries_o 1,2,3,4, then fault_o=1 and LOCKOUT held.
REQ-031 Lock loss in RUN: drop phy_locked_i -> ready_o=0 and core_reset_o=1 exactly 3 cycles later, full sequence repeats, retries_o unchanged.
REQ-032 Cal timeout then success: no cal_done_i for 4096 cycles -> FAULT, retries_o=1, retry completes to RUN when cal_done_i given.
REQ-033 Reset mid-operation: reset_i pulse for 1 cycle during CAL, and async_reset_n_i low between edges in LOCKOUT -> all outputs at REQ-026 values, retries_o=0, sequence restarts from PHY_RST.
REQ-034 Tie cases: lock rises on LOCK_TIMEOUT-th cycle -> CAL, not FAULT; cal_done_i on CAL_TIMEOUT-th cycle -> CORE_REL.
